// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Wide enough for a busy count of up to 64 cycles.
  localparam int unsigned CntWidth = 6;

  typedef enum logic [0:0] {
    StRun,
    StMduBusy
  } mdu_state_e;

  typedef enum logic [1:0] {
    CaseStall,
    CaseRedirect,
    CaseFetchWait,
    CaseNormal
  } hz_case_e;

endpackage

// File: rtl/mdu_timer.sv
// Tracks the multi-cycle multiply/divide unit: accepts a start and stays busy for its latency.
module mdu_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned DIV_LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic block,
  output logic busy
);

  localparam logic [CntWidth-1:0] MulCnt = CntWidth'(MUL_LATENCY - 1);
  localparam logic [CntWidth-1:0] DivCnt = CntWidth'(DIV_LATENCY - 1);

  mdu_state_e          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (start && !block) begin
          cnt_d   = is_div ? DivCnt : MulCnt;
          state_d = StMduBusy;
        end
      end
      StMduBusy: begin
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StMduBusy);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/redirect/fetch-wait decode plus perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned DIV_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UseRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_rt,
  input  logic        ID_Redirect,
  input  logic        ID_MDU_Start,
  input  logic        ID_MDU_Div,
  input  logic        ID_MDU_Read,
  input  logic        IMem_Ready,
  output logic        PC_Write,
  output logic        IF_Stall,
  output logic        IF_Flush,
  output logic        ID_EX_Flush,
  output logic        MDU_Busy,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count
);

  logic        load_use, mdu_haz, mdu_busy;
  hz_case_e    hz_case;
  logic [31:0] stall_cnt_q, flush_cnt_q;

  mdu_timer #(
    .MUL_LATENCY(MUL_LATENCY),
    .DIV_LATENCY(DIV_LATENCY)
  ) u_mdu_timer (
    .clk   (clk),
    .reset (reset),
    .start (ID_MDU_Start),
    .is_div(ID_MDU_Div),
    .block (load_use),
    .busy  (mdu_busy)
  );

  assign load_use = EX_MemRead && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (ID_UseRt && (EX_rt == ID_rt)));
  assign mdu_haz  = mdu_busy && (ID_MDU_Start || ID_MDU_Read);

  always_comb begin
    if (load_use || mdu_haz) begin
      hz_case = CaseStall;
    end else if (ID_Redirect) begin
      hz_case = CaseRedirect;
    end else if (!IMem_Ready) begin
      hz_case = CaseFetchWait;
    end else begin
      hz_case = CaseNormal;
    end
  end

  always_comb begin
    PC_Write    = 1'b0;
    IF_Stall    = 1'b0;
    IF_Flush    = 1'b0;
    ID_EX_Flush = 1'b0;
    if (reset) begin
      IF_Flush    = 1'b1;
      ID_EX_Flush = 1'b1;
    end else begin
      unique case (hz_case)
        CaseStall: begin
          IF_Stall    = 1'b1;
          ID_EX_Flush = 1'b1;
        end
        CaseRedirect: begin
          PC_Write = 1'b1;
          IF_Flush = 1'b1;
        end
        CaseFetchWait: IF_Flush = 1'b1;
        CaseNormal:    PC_Write = 1'b1;
        default:       PC_Write = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz_case == CaseStall)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (hz_case == CaseRedirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign MDU_Busy    = mdu_busy;
  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle MDU/reset/wrap sequences.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt, EX_rt;
  logic        ID_UseRt, EX_MemRead, ID_Redirect, ID_MDU_Start, ID_MDU_Div, ID_MDU_Read;
  logic        IMem_Ready;
  logic        PC_Write, IF_Stall, IF_Flush, ID_EX_Flush, MDU_Busy;
  logic [31:0] Stall_Count, Flush_Count;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MUL_LATENCY(4),
    .DIV_LATENCY(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .ID_UseRt    (ID_UseRt),
    .EX_MemRead  (EX_MemRead),
    .EX_rt       (EX_rt),
    .ID_Redirect (ID_Redirect),
    .ID_MDU_Start(ID_MDU_Start),
    .ID_MDU_Div  (ID_MDU_Div),
    .ID_MDU_Read (ID_MDU_Read),
    .IMem_Ready  (IMem_Ready),
    .PC_Write    (PC_Write),
    .IF_Stall    (IF_Stall),
    .IF_Flush    (IF_Flush),
    .ID_EX_Flush (ID_EX_Flush),
    .MDU_Busy    (MDU_Busy),
    .Stall_Count (Stall_Count),
    .Flush_Count (Flush_Count)
  );

  // Expected control word: {PC_Write, IF_Stall, IF_Flush, ID_EX_Flush, MDU_Busy}
  localparam logic [4:0] ExpNorm   = 5'b10000;
  localparam logic [4:0] ExpStall  = 5'b01010;
  localparam logic [4:0] ExpRedir  = 5'b10100;
  localparam logic [4:0] ExpWait   = 5'b00100;
  localparam logic [4:0] ExpReset  = 5'b00110;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, ex_rt;
    logic       use_rt, mem_read, redirect, start, is_div, rd, imem;
    logic [4:0] exp;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;
  logic [4:0]  exp_q[$];
  vec_t        tbl[$];

  function automatic vec_t mk(string name, logic [4:0] rs, logic [4:0] rt, logic use_rt,
                              logic mem_read, logic [4:0] ex_rt, logic redirect, logic start,
                              logic is_div, logic rd, logic imem, logic [4:0] exp);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.use_rt = use_rt; v.mem_read = mem_read;
    v.ex_rt = ex_rt; v.redirect = redirect; v.start = start; v.is_div = is_div;
    v.rd = rd; v.imem = imem; v.exp = exp;
    return v;
  endfunction

  function automatic logic [4:0] ctrl_now();
    return {PC_Write, IF_Stall, IF_Flush, ID_EX_Flush, MDU_Busy};
  endfunction

  task automatic cmp_ctrl(string name, logic [4:0] exp);
    checks++;
    if (ctrl_now() !== exp) begin
      failures++;
      $display("FAIL %s ctrl: got %b want %b", name, ctrl_now(), exp);
    end
  endtask

  task automatic cmp_cnt(string name);
    checks++;
    if (Stall_Count !== exp_stall || Flush_Count !== exp_flush) begin
      failures++;
      $display("FAIL %s counters: got stall=%0h flush=%0h want stall=%0h flush=%0h",
               name, Stall_Count, Flush_Count, exp_stall, exp_flush);
    end
  endtask

  // Drive at posedge+1, compare at negedge, return at the next posedge+1.
  task automatic step(vec_t v);
    logic [4:0] e;
    ID_rs = v.rs; ID_rt = v.rt; ID_UseRt = v.use_rt; EX_MemRead = v.mem_read;
    EX_rt = v.ex_rt; ID_Redirect = v.redirect; ID_MDU_Start = v.start;
    ID_MDU_Div = v.is_div; ID_MDU_Read = v.rd; IMem_Ready = v.imem;
    exp_q.push_back(v.exp);
    @(negedge clk);
    e = exp_q.pop_front();
    cmp_ctrl(v.name, e);
    cmp_cnt(v.name);
    if (e[3]) exp_stall = exp_stall + 32'd1;
    if (e[4] && e[2]) exp_flush = exp_flush + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle, mfhi, mul, div_s;
    idle  = mk("idle",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, ExpNorm);
    reset = 1'b1;
    ID_rs = '0; ID_rt = '0; ID_UseRt = 0; EX_MemRead = 0; EX_rt = '0; ID_Redirect = 0;
    ID_MDU_Start = 0; ID_MDU_Div = 0; ID_MDU_Read = 0; IMem_Ready = 1;
    #3;
    cmp_ctrl("reset_outputs", ExpReset);
    cmp_cnt("reset_counters");
    @(posedge clk); #1;
    reset = 1'b0;

    tbl.push_back(mk("normal",        5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 0, 1, ExpNorm));
    tbl.push_back(mk("load_use_rs",   5'd8, 5'd2, 0, 1, 5'd8, 0, 0, 0, 0, 1, ExpStall));
    tbl.push_back(mk("load_r0",       5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0, 1, ExpNorm));
    tbl.push_back(mk("load_use_rt",   5'd3, 5'd5, 1, 1, 5'd5, 0, 0, 0, 0, 1, ExpStall));
    tbl.push_back(mk("rt_not_used",   5'd3, 5'd5, 0, 1, 5'd5, 0, 0, 0, 0, 1, ExpNorm));
    tbl.push_back(mk("no_load",       5'd8, 5'd8, 1, 0, 5'd8, 0, 0, 0, 0, 1, ExpNorm));
    tbl.push_back(mk("redir_imemwait",5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0, 0, 0, ExpRedir));
    tbl.push_back(mk("fetch_wait",    5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0, 0, ExpWait));
    tbl.push_back(mk("redir_loaduse", 5'd9, 5'd2, 0, 1, 5'd9, 1, 0, 0, 0, 1, ExpStall));
    tbl.push_back(mk("redir",         5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0, 0, 1, ExpRedir));
    tbl.push_back(mk("mfhi_idle",     5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, ExpNorm));
    tbl.push_back(mk("start_blocked", 5'd4, 5'd0, 0, 1, 5'd4, 0, 1, 1, 0, 1, ExpStall));
    tbl.push_back(mk("not_accepted",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, ExpNorm));
    foreach (tbl[i]) step(tbl[i]);

    // Divide then mfhi: 32 busy/stall cycles, then mfhi advances.
    div_s = mk("div_start", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 1, ExpNorm);
    mfhi  = mk("mfhi_stall", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, ExpStall | 5'b00001);
    step(div_s);
    for (int i = 0; i < 32; i++) step(mfhi);
    mfhi.name = "mfhi_go"; mfhi.exp = ExpNorm;
    step(mfhi);

    // Back-to-back multiplies.
    mul = mk("mul_start", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 1, ExpNorm);
    step(mul);
    mul.name = "mul2_stall"; mul.exp = ExpStall | 5'b00001;
    for (int i = 0; i < 4; i++) step(mul);
    mul.name = "mul2_accept"; mul.exp = ExpNorm;
    step(mul);
    idle.name = "mul2_busy"; idle.exp = ExpNorm | 5'b00001;
    for (int i = 0; i < 4; i++) step(idle);
    idle.name = "mul2_done"; idle.exp = ExpNorm;
    step(idle);

    // Reset in the middle of a divide.
    step(div_s);
    idle.name = "div_busy"; idle.exp = ExpNorm | 5'b00001;
    for (int i = 0; i < 10; i++) step(idle);
    reset = 1'b1;
    #1;
    cmp_ctrl("reset_mid_div", ExpReset);
    exp_stall = 0;
    exp_flush = 0;
    cmp_cnt("reset_mid_div");
    @(posedge clk); #1;
    reset = 1'b0;
    mfhi.name = "mfhi_after_reset"; mfhi.exp = ExpNorm;
    step(mfhi);

    // Stall counter wrap.
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    @(posedge clk); #1;
    exp_stall = 32'hFFFF_FFFF;
    step(mk("wrap_stall", 5'd7, 5'd0, 0, 1, 5'd7, 0, 0, 0, 0, 1, ExpStall));
    step(mk("wrap_after", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, ExpNorm));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
